// File: rtl/spi_pkg.sv
// Shared state encoding, SPI mode constants and width helpers for the SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int bc_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// Control handshake plus SPI pins of the SPI master.
// The master modport is the controller's view; slave is the view of the logic that drives it.
interface spi_master_param_if #(
  parameter int DATA_W = 64
);
  import spi_pkg::*;

  localparam int BC_W = bc_width(DATA_W);

  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic [BC_W-1:0]   bit_count;
  logic              ss_n;
  logic              sck;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, bit_count, ss_n, sck, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, bit_count, ss_n, sck, mosi
  );

endinterface

// File: rtl/spi_sck_gen.sv
// SCK divider: toggles sck every CLK_DIV cycles while run is high, parked at CPOL otherwise.
// lead_edge/trail_edge are asserted in the cycle before the matching sck transition becomes visible.
module spi_sck_gen #(
  parameter int CLK_DIV = 24,
  parameter bit CPOL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sck,
  output logic lead_edge,
  output logic trail_edge
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          tick;

  assign tick       = run && (div_cnt == CW'(CLK_DIV - 1));
  assign lead_edge  = tick && (sck == CPOL);
  assign trail_edge = tick && (sck != CPOL);

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div_cnt <= '0;
      sck     <= CPOL;
    end else if (tick) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master: configurable width, SCK divider, CPOL/CPHA and chip-select timing.
// A start accepted in IDLE runs one transfer; busy covers the whole frame plus the CS gap.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int CLK_DIV  = 24,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0,
  parameter int CS_SETUP = 16,
  parameter int CS_HOLD  = 16,
  parameter int CS_GAP   = 8
) (
  input logic                clk,
  input logic                rst,
  spi_master_param_if.master bus
);

  localparam int EDGES  = 2 * DATA_W;
  localparam int EC_W   = $clog2(EDGES + 1);
  localparam int BC_W   = bc_width(DATA_W);
  localparam int T_MAX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int T_MAX  = (T_MAX0 > CS_GAP + 1) ? T_MAX0 : CS_GAP + 1;
  localparam int TW     = $clog2(T_MAX + 1);

  spi_state_t        state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [EC_W-1:0]   edge_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] rx_q;
  logic [BC_W-1:0]   bit_cnt;
  logic              mosi_q;
  logic              done_q;
  logic              run;
  logic              accept;
  logic              finish;
  logic              lead_edge;
  logic              trail_edge;
  logic              edge_stb;
  logic              sample_stb;
  logic              shift_stb;

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_sck_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .sck        (bus.sck),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  assign edge_stb   = lead_edge | trail_edge;
  assign sample_stb = CPHA ? trail_edge : lead_edge;
  assign shift_stb  = CPHA ? lead_edge : trail_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // The divider is released on the last SETUP cycle so edge 1 lands CLK_DIV cycles later.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    run       = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SETUP;
          timer_nxt = '0;
        end
      end
      SETUP: begin
        if (timer == TW'(CS_SETUP - 1)) begin
          run       = 1'b1;
          state_nxt = XFER;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      XFER: begin
        run = 1'b1;
        if (edge_stb && (edge_cnt == EC_W'(EDGES - 1))) begin
          state_nxt = HOLD;
          timer_nxt = '0;
        end
      end
      HOLD: begin
        if (timer == TW'(CS_HOLD - 1)) begin
          finish    = 1'b1;
          state_nxt = GAP;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      GAP: begin
        if (timer == TW'(CS_GAP)) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // The next outgoing bit is always shreg's MSB, since one sample has shifted in per bit sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      rx_q     <= '0;
      bit_cnt  <= '0;
      edge_cnt <= '0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        shreg    <= bus.tx_data;
        bit_cnt  <= '0;
        edge_cnt <= '0;
        mosi_q   <= CPHA ? 1'b0 : bus.tx_data[DATA_W-1];
      end else begin
        if (edge_stb && (edge_cnt != EC_W'(EDGES))) begin
          edge_cnt <= edge_cnt + EC_W'(1);
        end
        if (sample_stb) begin
          shreg   <= {shreg[DATA_W-2:0], bus.miso};
          bit_cnt <= bit_cnt + BC_W'(1);
        end
        if (shift_stb && (bit_cnt != BC_W'(DATA_W))) begin
          mosi_q <= shreg[DATA_W-1];
        end
        if (finish) begin
          mosi_q <= 1'b0;
          rx_q   <= shreg;
        end
      end
    end
  end

  assign bus.ss_n      = !((state == SETUP) || (state == XFER) || (state == HOLD));
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.rx_data   = rx_q;
  assign bus.bit_count = bit_cnt;
  assign bus.mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench: two 8-bit masters (mode 0 and mode 3) share a timing profile, plus one default-parameter master.
// Cycle n below means n clocks after the edge that accepted start; outputs are read 1 time unit after each edge.
module tb_spi_master_param;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_param_if #(.DATA_W(8))  b0 ();
  spi_master_param_if #(.DATA_W(8))  b3 ();
  spi_master_param_if #(.DATA_W(64)) bd ();

  logic loop0 = 1'b0, loop3 = 1'b0, mc0 = 1'b0, mc3 = 1'b0;
  assign b0.miso = loop0 ? b0.mosi : mc0;
  assign b3.miso = loop3 ? b3.mosi : mc3;
  assign bd.miso = ~bd.mosi;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .CPOL(SPI_MODE0[1]), .CPHA(SPI_MODE0[0]),
                     .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .CPOL(SPI_MODE3[1]), .CPHA(SPI_MODE3[0]),
                     .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(1)) u3 (.clk(clk), .rst(rst), .bus(b3));
  spi_master_param ud (.clk(clk), .rst(rst), .bus(bd));

  int tests = 0;
  int fails = 0;
  int sel = 0;

  logic       s_ssn, s_sck, s_mosi, s_done, s_busy;
  logic [7:0] s_rx;
  logic [3:0] s_bc;

  always_comb begin
    if (sel == 1) begin
      s_ssn = b3.ss_n; s_sck = b3.sck; s_mosi = b3.mosi; s_done = b3.done;
      s_busy = b3.busy; s_rx = b3.rx_data; s_bc = b3.bit_count;
    end else begin
      s_ssn = b0.ss_n; s_sck = b0.sck; s_mosi = b0.mosi; s_done = b0.done;
      s_busy = b0.busy; s_rx = b0.rx_data; s_bc = b0.bit_count;
    end
  end

  typedef struct {
    int         sel;
    logic [7:0] tx;
    logic       loopback;
    logic       miso_val;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
    int         poke;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input int s, input logic st, input logic [7:0] tx);
    if (s == 1) begin
      b3.start = st; b3.tx_data = tx;
    end else begin
      b0.start = st; b0.tx_data = tx;
    end
  endtask

  // One 8-bit transfer; expected timing: ss_n low cycles 1..35, done in cycle 36, 16 sck edges.
  task automatic run_small(input int s, input logic [7:0] tx, input logic lp, input logic mv,
                           input logic [7:0] erx, input logic [7:0] emosi, input int poke,
                           input string tag);
    int         fall_n, rise_n, done_n, ndone, nedge, nfall, viol;
    logic       cp, ch, psck, pmosi, pssn, leading;
    logic [7:0] mseq, rx_at;
    logic [3:0] bc_at;
    cp = (s == 1); ch = (s == 1);
    fall_n = -1; rise_n = -1; done_n = -1; ndone = 0; nedge = 0; nfall = 0; viol = 0;
    mseq = '0; rx_at = '0; bc_at = '0;
    sel = s;
    if (s == 1) begin loop3 = lp; mc3 = mv; end
    else begin loop0 = lp; mc0 = mv; end
    #0;
    chk($sformatf("%s idle_sck", tag), 64'(s_sck), 64'(cp));
    set_in(s, 1'b1, tx);
    @(posedge clk); #1;
    set_in(s, 1'b0, ~tx);
    psck = cp; pmosi = 1'b0; pssn = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (n == poke) set_in(s, 1'b1, ~tx);
      if (poke > 0 && n == poke + 1) set_in(s, 1'b0, ~tx);
      if (pssn && !s_ssn) begin nfall++; if (fall_n < 0) fall_n = n; end
      if (!pssn && s_ssn && rise_n < 0) rise_n = n;
      if (s_done) begin ndone++; done_n = n; rx_at = s_rx; bc_at = s_bc; end
      leading = (psck == cp);
      if (s_sck != psck) begin
        nedge++;
        if (leading != ch) mseq = {mseq[6:0], pmosi};
      end
      if (s_mosi != pmosi && !pssn && !s_ssn && !((s_sck != psck) && (leading == ch))) viol++;
      psck = s_sck; pmosi = s_mosi; pssn = s_ssn;
    end
    chk($sformatf("%s ss_fall", tag), 64'(fall_n), 64'(1));
    chk($sformatf("%s ss_rise", tag), 64'(rise_n), 64'(36));
    chk($sformatf("%s done_cycle", tag), 64'(done_n), 64'(36));
    chk($sformatf("%s done_count", tag), 64'(ndone), 64'(1));
    chk($sformatf("%s ss_fall_count", tag), 64'(nfall), 64'(1));
    chk($sformatf("%s sck_edges", tag), 64'(nedge), 64'(16));
    chk($sformatf("%s rx_data", tag), 64'(rx_at), 64'(erx));
    chk($sformatf("%s bit_count", tag), 64'(bc_at), 64'(8));
    chk($sformatf("%s mosi_word", tag), 64'(mseq), 64'(emosi));
    chk($sformatf("%s mosi_on_shift_edge_only", tag), 64'(viol), 64'(0));
  endtask

  initial begin
    b0.start = 1'b0; b0.tx_data = '0;
    b3.start = 1'b0; b3.tx_data = '0;
    bd.start = 1'b0; bd.tx_data = '0;

    vecs[0] = '{0, 8'hA5, 1'b1, 1'b0, 8'hA5, 8'hA5, 0};
    vecs[1] = '{1, 8'h3C, 1'b0, 1'b1, 8'hFF, 8'h3C, 0};
    vecs[2] = '{0, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h5A, 0};
    vecs[3] = '{1, 8'h81, 1'b1, 1'b0, 8'h81, 8'h81, 0};
    vecs[4] = '{0, 8'hC3, 1'b1, 1'b0, 8'hC3, 8'hC3, 10};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst ss_n", 64'(b0.ss_n), 64'(1));
    chk("rst sck_mode0", 64'(b0.sck), 64'(0));
    chk("rst sck_mode3", 64'(b3.sck), 64'(1));
    chk("rst busy", 64'(b0.busy), 64'(0));
    chk("rst done", 64'(b0.done), 64'(0));
    chk("rst mosi", 64'(b0.mosi), 64'(0));
    chk("rst bit_count", 64'(b0.bit_count), 64'(0));
    chk("rst rx_data", 64'(b0.rx_data), 64'(0));
    chk("rst default ss_n", 64'(bd.ss_n), 64'(1));
    chk("rst default busy", 64'(bd.busy), 64'(0));

    for (int i = 0; i < 5; i++) begin
      run_small(vecs[i].sel, vecs[i].tx, vecs[i].loopback, vecs[i].miso_val,
                vecs[i].exp_rx, vecs[i].exp_mosi, vecs[i].poke, $sformatf("vec%0d", i));
    end

    // Reset landing right after sck edge 5 of a mode-0 transfer.
    begin
      int   ne, nd;
      logic ps, hit, hi;
      ne = 0; nd = 0; ps = 1'b0; hit = 1'b0; hi = 1'b1;
      sel = 0; loop0 = 1'b1;
      set_in(0, 1'b1, 8'h3C);
      @(posedge clk); #1;
      set_in(0, 1'b0, 8'h3C);
      for (int n = 0; n < 40; n++) begin
        if (b0.sck != ps) ne++;
        ps = b0.sck;
        if (ne == 5) begin hit = 1'b1; break; end
        @(posedge clk); #1;
      end
      chk("rst_mid edge5_reached", 64'(hit), 64'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid ss_n", 64'(b0.ss_n), 64'(1));
      chk("rst_mid sck", 64'(b0.sck), 64'(0));
      chk("rst_mid busy", 64'(b0.busy), 64'(0));
      chk("rst_mid rx_data", 64'(b0.rx_data), 64'(0));
      chk("rst_mid done", 64'(b0.done), 64'(0));
      chk("rst_mid bit_count", 64'(b0.bit_count), 64'(0));
      chk("rst_mid mosi", 64'(b0.mosi), 64'(0));
      rst = 1'b0;
      for (int n = 0; n < 45; n++) begin
        @(posedge clk); #1;
        if (b0.done) nd++;
        if (!b0.ss_n) hi = 1'b0;
      end
      chk("rst_mid no_done_after", 64'(nd), 64'(0));
      chk("rst_mid ss_n_stays_high", 64'(hi), 64'(1));
      run_small(0, 8'h96, 1'b1, 1'b0, 8'h96, 8'h96, 0, "after_rst");
    end

    // Default parameters: done at 16 + 2*64*24 + 16 = 3104, busy falls 9 cycles later.
    begin
      logic [63:0] tx, dseq, drx;
      logic [6:0]  dbc;
      logic        dps, dpm;
      int          dn_done, dn_busy, dnd, dne;
      tx = 64'h0123_4567_89AB_CDEF;
      dseq = '0; drx = '0; dbc = '0; dps = 1'b0; dpm = 1'b0;
      dn_done = -1; dn_busy = -1; dnd = 0; dne = 0;
      bd.tx_data = tx; bd.start = 1'b1;
      @(posedge clk); #1;
      bd.start = 1'b0; bd.tx_data = '1;
      for (int n = 1; n <= 3200; n++) begin
        if (n > 1) begin @(posedge clk); #1; end
        if (bd.sck != dps) begin
          dne++;
          if (dps == 1'b0) dseq = {dseq[62:0], dpm};
        end
        if (bd.done) begin dnd++; dn_done = n; drx = bd.rx_data; dbc = bd.bit_count; end
        if (dn_done > 0 && dn_busy < 0 && !bd.busy) dn_busy = n;
        dps = bd.sck; dpm = bd.mosi;
      end
      chk("dflt done_cycle", 64'(dn_done), 64'(3104));
      chk("dflt done_count", 64'(dnd), 64'(1));
      chk("dflt busy_fall_after_done", 64'(dn_busy - dn_done), 64'(9));
      chk("dflt mosi_word", dseq, 64'h0123_4567_89AB_CDEF);
      chk("dflt rx_data", drx, 64'hFEDC_BA98_7654_3210);
      chk("dflt sck_edges", 64'(dne), 64'(128));
      chk("dflt bit_count", 64'(dbc), 64'(64));
    end

    // start held high on the mode-3 master: dones at 36, 74, 112; ss_n high 2 cycles after each done cycle.
    begin
      int   nd, nf, last_done;
      logic pssn;
      nd = 0; nf = 0; last_done = -1; pssn = 1'b1;
      sel = 1; loop3 = 1'b1;
      set_in(1, 1'b1, 8'h5A);
      for (int n = 1; n <= 200; n++) begin
        @(posedge clk); #1;
        if (pssn && !b3.ss_n) begin
          nf++;
          if (last_done >= 0) chk($sformatf("b2b gap%0d", nf), 64'(n - last_done - 1), 64'(2));
        end
        if (b3.done) begin
          nd++;
          last_done = n;
          chk($sformatf("b2b rx%0d", nd), 64'(b3.rx_data), 64'(8'h5A));
          if (nd == 3) set_in(1, 1'b0, 8'h5A);
        end
        pssn = b3.ss_n;
      end
      chk("b2b done_count", 64'(nd), 64'(3));
      chk("b2b frame_count", 64'(nf), 64'(3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised, full-duplex SPI master. It is the successor to the fixed 64-bit, mode-0-only, button-triggered transmitter. It adds:
- configurable word width, SCK divider, CPOL/CPHA mode and chip-select setup/hold/gap timing;
- MISO capture;
- a start/busy/done handshake, so the AES control FSM (or a separate debouncer) drives transfers.

It sits between the AES datapath (plaintext/ciphertext words) and the external SPI target.

Parameters:
DATA_W, 64, bits per transfer (>=2), shifted MSB first
CLK_DIV, 24, clk cycles per SCK half-period (>=1)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading edge / sample on trailing edge
CS_SETUP, 16, clk cycles from ss_n fall to first SCK edge (>=1)
CS_HOLD, 16, clk cycles from last SCK edge to ss_n rise (>=1)
CS_GAP, 8, minimum clk cycles ss_n stays high before the next start is accepted (>=0)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  transfer request; sampled only in IDLE
tx_data  in  DATA_W  word to send; latched on accepted start
busy  out  1  high from the cycle after an accepted start through the end of GAP
done  out  1  one-cycle pulse when a transfer completes
rx_data  out  DATA_W  captured MISO word; valid from the done cycle until the next done
bit_count  out  $clog2(DATA_W+1)  bits sampled so far in the current transfer
ss_n  out  1  chip select, active-low
sck  out  1  SPI clock
mosi  out  1  serial data out
miso  in  1  serial data in (already synchronised externally)

Behaviour:
- Reset (sync, high), effective on the cycle after rst is sampled, regardless of state (including mid-transfer):
  - state = IDLE; ss_n = 1; sck = CPOL; mosi = 0; busy = 0; done = 0; bit_count = 0; rx_data = 0; shift register = 0.
- FSM states: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
- IDLE:
  - start = 1 at cycle T0: latch tx_data into the shift register.
  - At T0+1: ss_n = 0, busy = 1, state = SETUP, bit_count = 0.
  - At T0+1, if CPHA = 0: mosi = tx_data[DATA_W-1]; if CPHA = 1: mosi = 0.
- SETUP: lasts CS_SETUP cycles. The half-period counter starts on the last SETUP cycle.
- XFER: SCK edge k (k = 1..2*DATA_W) toggles sck at cycle T0 + CS_SETUP + k*CLK_DIV.
  - Leading edges are odd k; trailing edges are even k.
  - Sample edge: miso is shifted into the LSB of the shift register and bit_count increments.
  - Shift edge: mosi takes the next MSB.
  - CPHA = 0: no shift on the final trailing edge (k = 2*DATA_W).
  - CPHA = 1: mosi is updated on every leading edge, including the first.
- HOLD: begins after edge 2*DATA_W, with sck back at CPOL.
  - At T0 + CS_SETUP + 2*DATA_W*CLK_DIV + CS_HOLD: ss_n = 1, mosi = 0, done = 1 for exactly one cycle, rx_data = shift register.
- GAP:
  - busy stays high for CS_GAP further cycles, then IDLE with busy = 0.
  - With CS_GAP = 0, busy falls in the cycle after done.
- Start handling:
  - start while busy is ignored (not queued).
  - start held high continuously gives back-to-back transfers, each separated by CS_GAP+1 ss_n-high cycles.
- Counters: the half-period counter wraps at CLK_DIV-1. The edge counter is $clog2(2*DATA_W+1) bits and saturates; it never wraps.
- tx_data changes after acceptance have no effect on the current transfer.
- miso is ignored outside sample edges.

Decomposition:
- spi_pkg:
  - spi_state_t enum (IDLE, SETUP, XFER, HOLD, GAP);
  - a function for bit_count width;
  - constants SPI_MODE0..3 as {CPOL,CPHA} pairs.
- Sub-module spi_sck_gen (param CLK_DIV, CPOL):
  - inputs: run, rst;
  - outputs: sck plus one-cycle lead_edge/trail_edge strobes;
  - holds sck = CPOL when not running.
- Top-level module: FSM, shift register, CS timers.

Test Plan:
1. Mode 0, DATA_W = 8, CLK_DIV = 2, CS_SETUP = 2, CS_HOLD = 2, CS_GAP = 1, tx = 0xA5, miso looped to mosi -> 16 sck edges; ss_n low T0+1..T0+35; done at T0+36; rx_data = 0xA5; bit_count = 8.
2. Mode 3 (CPOL = 1, CPHA = 1), tx = 0x3C, miso tied to constant 1 -> sck idles high; mosi bits 0,0,1,1,1,1,0,0 change on falling edges; rx_data = 0xFF.
3. Default params, tx = 64'h0123_4567_89AB_CDEF -> 64 bits MSB first match tx; done exactly once; busy falls CS_GAP+1 cycles after done.
4. start pulsed again mid-XFER, and tx_data changed, -> no second transfer; transmitted word unchanged; exactly one done.
5. rst asserted at edge 5 of a transfer -> next cycle ss_n = 1, sck = CPOL, busy = 0, rx_data = 0, no done; a new start then runs a full correct transfer.
6. start held high across three transfers -> three done pulses; ss_n high for exactly CS_GAP+1 cycles between them.
